// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// The pipeline side drives the request, the divider returns busy/done and the result.
interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a_in;
  logic [XLEN-1:0] b_in;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] c_out;

  modport master (
    output start, funct3, a_in, b_in, flush,
    input  busy, done, c_out
  );

  modport slave (
    input  start, funct3, a_in, b_in, flush,
    output busy, done, c_out
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow bypass the iteration and finish on the next cycle.
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  div_unit_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] cOut_q, cOut_d;
  logic            isRem_q, isRem_d;
  logic            negQ_q, negQ_d;
  logic            negR_q, negR_d;

  logic            opSigned, opRem, aNeg, bNeg, bZero, ovf;
  logic [XLEN-1:0] aAbs, bAbs;
  logic [XLEN:0]   shifted, trial;
  logic            keep;
  logic [XLEN-1:0] quoFix, remFix;

  // Unknown funct3 encodings fall back to DIVU: unsigned, quotient.
  assign opSigned = (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
  assign opRem    = (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);
  assign aNeg     = opSigned & bus.a_in[XLEN-1];
  assign bNeg     = opSigned & bus.b_in[XLEN-1];
  assign aAbs     = aNeg ? -bus.a_in : bus.a_in;
  assign bAbs     = bNeg ? -bus.b_in : bus.b_in;
  assign bZero    = (bus.b_in == '0);
  assign ovf      = opSigned && (bus.a_in == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.b_in);

  // The dividend lives in quo_q and shifts out MSB-first while quotient bits shift in.
  assign shifted = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
  assign trial   = shifted - {1'b0, dvs_q};
  assign keep    = rem_q[XLEN] | ~trial[XLEN];

  assign quoFix = negQ_q ? -quo_q : quo_q;
  assign remFix = negR_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cOut_d  = cOut_q;
    isRem_d = isRem_q;
    negQ_d  = negQ_q;
    negR_d  = negR_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          isRem_d = opRem;
          negQ_d  = aNeg ^ bNeg;
          negR_d  = aNeg;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = aAbs;
          dvs_d   = bAbs;
          if (bZero) begin
            cOut_d  = opRem ? bus.a_in : '1;
            state_d = DONE;
          end else if (ovf) begin
            cOut_d  = opRem ? '0 : bus.a_in;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          rem_d = keep ? trial : shifted;
          quo_d = {quo_q[XLEN-2:0], keep};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) state_d = FIX;
        end
      end
      FIX: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          cOut_d  = isRem_q ? remFix : quoFix;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cOut_q  <= '0;
      isRem_q <= 1'b0;
      negQ_q  <= 1'b0;
      negR_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cOut_q  <= cOut_d;
      isRem_q <= isRem_d;
      negQ_q  <= negQ_d;
      negR_q  <= negR_d;
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.c_out = cOut_q;

endmodule
